// File: rtl/alu_exec_unit_if.sv
// Handshake/data bundle between the pipeline and the execute-stage ALU.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready.
interface alu_exec_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Operation;
  logic [DATA_W-1:0] SrcA;
  logic [DATA_W-1:0] SrcB;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ALUResult;
  logic              Zero;

  modport master (
    output flush, in_valid, Operation, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, Zero
  );

  modport slave (
    input  flush, in_valid, Operation, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, Zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic ops, shifts done one bit per cycle.
// Single-entry; IDLE accepts, SHIFT iterates, DONE holds the result until taken.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5   // must equal log2(DATA_W)
) (
  input  logic       clk,
  input  logic       reset,
  alu_exec_unit_if.slave bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_OR2  = 4'b1001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1100;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]          shop_q, shop_d;

  logic                is_shift;
  logic [SHAMT_W-1:0]  amt;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W-1:0]   shifted;
  logic                in_ready;
  logic                accept;

  assign amt      = bus.SrcB[SHAMT_W-1:0];
  assign is_shift = (bus.Operation == OP_SLL) || (bus.Operation == OP_SRL) ||
                    (bus.Operation == OP_SRA);

  // Single-cycle datapath; a shift code lands here only with amount 0, giving A.
  always_comb begin
    alu_res = '0;
    case (bus.Operation)
      OP_AND:                 alu_res = bus.SrcA & bus.SrcB;
      OP_OR, OP_OR2:          alu_res = bus.SrcA | bus.SrcB;
      OP_ADD:                 alu_res = bus.SrcA + bus.SrcB;
      OP_SUB:                 alu_res = bus.SrcA - bus.SrcB;
      OP_XOR:                 alu_res = bus.SrcA ^ bus.SrcB;
      OP_SLL, OP_SRL, OP_SRA: alu_res = bus.SrcA;
      OP_EQ:                  alu_res = {{(DATA_W-1){1'b0}}, (bus.SrcA == bus.SrcB)};
      OP_SLT:                 alu_res = {{(DATA_W-1){1'b0}},
                                         ($signed(bus.SrcA) < $signed(bus.SrcB))};
      default:                alu_res = '0;
    endcase
  end

  // shop_q holds Operation[1:0]: 00 SLL, 01 SRL, 11 SRA.
  always_comb begin
    shifted = work_q;
    case (shop_q)
      2'b00:   shifted = {work_q[DATA_W-2:0], 1'b0};
      2'b01:   shifted = {1'b0, work_q[DATA_W-1:1]};
      2'b11:   shifted = {work_q[DATA_W-1], work_q[DATA_W-1:1]};
      default: shifted = work_q;
    endcase
  end

  // DONE can hand off its result and take a new op in the same cycle.
  assign in_ready = !bus.flush &&
                    ((state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    shop_d   = shop_q;
    if (bus.flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_SHIFT: begin
          work_d = shifted;
          cnt_d  = cnt_q - 1'b1;
          if (cnt_q == SHAMT_W'(1)) begin
            result_d = shifted;
            state_d  = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        if (is_shift && (amt != '0)) begin
          work_d  = bus.SrcA;
          cnt_d   = amt;
          shop_d  = bus.Operation[1:0];
          state_d = S_SHIFT;
        end else begin
          result_d = alu_res;
          state_d  = S_DONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      shop_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      shop_q   <= shop_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: arithmetic, logic, iterative shifts, backpressure,
// flush and asynchronous reset; expected values are hand-computed constants.
module tb_alu_exec_unit;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR2 = 4'b1001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_SLT = 4'b1100;
  localparam logic [3:0] OP_UND = 4'b1111;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;

  alu_exec_unit_if bus_if ();

  alu_exec_unit dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy);
    bit done;
    @(negedge clk);
    bus_if.in_valid  = 1'b1;
    bus_if.Operation = op;
    bus_if.SrcA      = a;
    bus_if.SrcB      = b;
    @(posedge clk);
    #1;
    bus_if.in_valid  = 1'b0;
    bus_if.Operation = 4'($urandom_range(0, 15));
    bus_if.SrcA      = $urandom;
    bus_if.SrcB      = $urandom;
    lat  = 0;
    busy = 0;
    done = 1'b0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus_if.out_valid) done = 1'b1;
      else if (!bus_if.in_ready) busy++;
    end
  endtask

  task automatic take();
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.out_ready = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    bus_if.flush = 1'b0; bus_if.in_valid = 1'b0; bus_if.out_ready = 1'b0;
    bus_if.Operation = '0; bus_if.SrcA = '0; bus_if.SrcB = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus_if.ALUResult !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", bus_if.ALUResult, 32'h0); end
    n_cmp++; if (bus_if.Zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero: got %b expected 1", bus_if.Zero); end
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); end
    n_cmp++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus_if.in_ready); end
  endtask

  task automatic test_arith();
    int lat, busy;
    do_op(OP_ADD, 32'h7FFFFFFF, 32'h1, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h80000000) begin n_fail++; $display("FAIL add_ovf: got %h expected %h", bus_if.ALUResult, 32'h80000000); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_cmp++; if (bus_if.Zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", bus_if.Zero); end
    take();
    do_op(OP_SUB, 32'h0, 32'h1, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub_wrap: got %h expected %h", bus_if.ALUResult, 32'hFFFFFFFF); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL sub_latency: got %0d expected 1", lat); end
    n_cmp++; if (bus_if.Zero !== 1'b0) begin n_fail++; $display("FAIL sub_zero: got %b expected 0", bus_if.Zero); end
    take();
    do_op(OP_SUB, 32'h5, 32'h5, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0) begin n_fail++; $display("FAIL sub_equal: got %h expected 0", bus_if.ALUResult); end
    n_cmp++; if (bus_if.Zero !== 1'b1) begin n_fail++; $display("FAIL sub_equal_zero: got %b expected 1", bus_if.Zero); end
    take();
  endtask

  task automatic test_logic_compare();
    int lat, busy;
    do_op(OP_AND, 32'h0000F0F0, 32'h0000FF00, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0000F000) begin n_fail++; $display("FAIL and: got %h expected %h", bus_if.ALUResult, 32'h0000F000); end
    take();
    do_op(OP_OR2, 32'h0000F0F0, 32'h00000F0F, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0000FFFF) begin n_fail++; $display("FAIL or_alias: got %h expected %h", bus_if.ALUResult, 32'h0000FFFF); end
    take();
    do_op(OP_SLT, 32'hFFFFFFFF, 32'h1, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h1) begin n_fail++; $display("FAIL slt_neg: got %h expected 1", bus_if.ALUResult); end
    take();
    do_op(OP_SLT, 32'h1, 32'hFFFFFFFF, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0) begin n_fail++; $display("FAIL slt_pos: got %h expected 0", bus_if.ALUResult); end
    take();
    do_op(OP_EQ, 32'h1234, 32'h1234, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h1) begin n_fail++; $display("FAIL eq_same: got %h expected 1", bus_if.ALUResult); end
    take();
    do_op(OP_EQ, 32'h1234, 32'h1235, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0) begin n_fail++; $display("FAIL eq_diff: got %h expected 0", bus_if.ALUResult); end
    take();
    do_op(OP_UND, 32'h5, 32'h3, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h0) begin n_fail++; $display("FAIL undef_result: got %h expected 0", bus_if.ALUResult); end
    n_cmp++; if (bus_if.Zero !== 1'b1) begin n_fail++; $display("FAIL undef_zero: got %b expected 1", bus_if.Zero); end
    take();
  endtask

  task automatic test_shift();
    int lat, busy;
    do_op(OP_SRA, 32'h80000000, 32'd31, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sra31: got %h expected %h", bus_if.ALUResult, 32'hFFFFFFFF); end
    n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL sra31_latency: got %0d expected 32", lat); end
    n_cmp++; if (busy !== 31) begin n_fail++; $display("FAIL sra31_in_ready_low: got %0d expected 31", busy); end
    take();
    do_op(OP_SRL, 32'h80000000, 32'd31, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h1) begin n_fail++; $display("FAIL srl31: got %h expected 1", bus_if.ALUResult); end
    n_cmp++; if (lat !== 32) begin n_fail++; $display("FAIL srl31_latency: got %0d expected 32", lat); end
    take();
    do_op(OP_SLL, 32'hDEADBEEF, 32'h0, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sll0: got %h expected %h", bus_if.ALUResult, 32'hDEADBEEF); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL sll0_latency: got %0d expected 1", lat); end
    take();
    // upper bits of B are ignored: amount is B[4:0] = 4
    do_op(OP_SLL, 32'h00000003, 32'hFFFFFFE4, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h00000030) begin n_fail++; $display("FAIL sll4: got %h expected %h", bus_if.ALUResult, 32'h00000030); end
    n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL sll4_latency: got %0d expected 5", lat); end
    take();
  endtask

  task automatic test_backpressure();
    int lat, busy;
    do_op(OP_ADD, 32'd3, 32'd4, lat, busy);
    for (int i = 0; i < 5; i++) begin
      bus_if.in_valid  = 1'b1;
      bus_if.Operation = 4'($urandom_range(0, 15));
      bus_if.SrcA      = $urandom;
      bus_if.SrcB      = $urandom;
      #1;
      n_cmp++; if (bus_if.ALUResult !== 32'd7 || bus_if.Zero !== 1'b0 || bus_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got %h/%b/%b expected 00000007/0/1", i, bus_if.ALUResult, bus_if.Zero, bus_if.out_valid); end
      n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus_if.in_ready); end
      @(negedge clk);
    end
    bus_if.out_ready = 1'b1;
    bus_if.in_valid  = 1'b1;
    bus_if.Operation = OP_ADD; bus_if.SrcA = 32'd10; bus_if.SrcB = 32'd20;
    #1;
    n_cmp++; if (bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus_if.in_ready); end
    @(posedge clk); #1;
    bus_if.Operation = OP_SUB; bus_if.SrcA = 32'd100; bus_if.SrcB = 32'd1;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b1 || bus_if.ALUResult !== 32'd30) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/0000001e", bus_if.out_valid, bus_if.ALUResult); end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b1 || bus_if.ALUResult !== 32'd99) begin n_fail++; $display("FAIL b2b_second: got %b/%h expected 1/00000063", bus_if.out_valid, bus_if.ALUResult); end
    @(posedge clk); #1;
    bus_if.out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL b2b_idle: got %b/%0d expected 0/0", bus_if.out_valid, dbg_state); end
  endtask

  task automatic test_flush();
    int  lat, busy;
    bit  seen_valid;
    bus_if.in_valid = 1'b1;
    bus_if.Operation = OP_SLL; bus_if.SrcA = 32'h1; bus_if.SrcB = 32'd10;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL flush_shift_state: got %0d expected 1", dbg_state); end
    @(negedge clk);
    bus_if.flush = 1'b1;
    bus_if.in_valid = 1'b1; bus_if.Operation = OP_ADD; bus_if.SrcA = 32'd5; bus_if.SrcB = 32'd5;
    #1;
    n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_shift_in_ready: got %b expected 0", bus_if.in_ready); end
    @(posedge clk); #1;
    bus_if.flush = 1'b0; bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b0 || dbg_state !== 2'd0 || bus_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_shift_idle: got %b/%0d/%b expected 0/0/1", bus_if.out_valid, dbg_state, bus_if.in_ready); end
    n_cmp++; if (bus_if.ALUResult !== 32'd99) begin n_fail++; $display("FAIL flush_shift_keep: got %h expected 00000063", bus_if.ALUResult); end
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.out_valid) seen_valid = 1'b1;
    end
    n_cmp++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL flush_shift_late_valid: got %b expected 0", seen_valid); end

    do_op(OP_ADD, 32'd1, 32'd1, lat, busy);
    bus_if.flush = 1'b1;
    bus_if.in_valid = 1'b1; bus_if.Operation = OP_ADD; bus_if.SrcA = 32'd5; bus_if.SrcB = 32'd5;
    #1;
    n_cmp++; if (bus_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_done_in_ready: got %b expected 0", bus_if.in_ready); end
    @(posedge clk); #1;
    bus_if.flush = 1'b0; bus_if.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.out_valid !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL flush_done_idle: got %b/%0d expected 0/0", bus_if.out_valid, dbg_state); end
    n_cmp++; if (bus_if.ALUResult !== 32'd2) begin n_fail++; $display("FAIL flush_done_keep: got %h expected 00000002", bus_if.ALUResult); end
    do_op(OP_SLL, 32'd3, 32'd2, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'd12 || lat !== 3) begin n_fail++; $display("FAIL flush_recover: got %h lat %0d expected 0000000c lat 3", bus_if.ALUResult, lat); end
    take();
  endtask

  task automatic test_reset_mid_shift();
    int lat, busy;
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.Operation = OP_SRA; bus_if.SrcA = 32'h80000000; bus_if.SrcB = 32'd20;
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected 1", dbg_state); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus_if.ALUResult !== 32'h0 || bus_if.Zero !== 1'b1 || bus_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h/%b/%b expected 00000000/1/0", bus_if.ALUResult, bus_if.Zero, bus_if.out_valid); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_if.in_ready !== 1'b1 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_mid_release: got %b/%0d expected 1/0", bus_if.in_ready, dbg_state); end
    do_op(OP_XOR, 32'h0000F0F0, 32'h0000FF00, lat, busy);
    n_cmp++; if (bus_if.ALUResult !== 32'h00000FF0 || lat !== 1) begin n_fail++; $display("FAIL rst_mid_xor: got %h lat %0d expected 00000ff0 lat 1", bus_if.ALUResult, lat); end
    take();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_arith();
    test_logic_compare();
    test_shift();
    test_backpressure();
    test_flush();
    test_reset_mid_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage ALU that consumes the 4-bit `Operation` code produced by the ALU controller, together with two operands, and returns a registered result plus a zero flag to the pipeline. Single-cycle operations complete in one cycle. Shifts run iteratively, one bit per cycle, so they do not need a barrel shifter. The unit is single-entry, with valid/ready handshakes on both the input and output sides, and a synchronous flush for branch redirects.

## Interface
- `DATA_W`, default 32, operand/result width.
- `SHAMT_W`, default 5, shift-amount width; must equal log2(`DATA_W`).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous; drops any in-flight or held operation.
- `in_valid`  in  1  an operation is presented.
- `in_ready`  out  1  the unit accepts the operation this cycle.
- `Operation`  in  4  ALU operation code from the controller.
- `SrcA`  in  `DATA_W`  operand A.
- `SrcB`  in  `DATA_W`  operand B; for shifts, the shift amount is `SrcB[SHAMT_W-1:0]`.
- `out_valid`  out  1  result held and valid.
- `out_ready`  in  1  the consumer takes the result this cycle.
- `ALUResult`  out  `DATA_W`  result.
- `Zero`  out  1  asserted when `ALUResult == 0`.

## Operation
Operation encoding (all arithmetic is modulo 2^`DATA_W`):
- 0000 AND
- 0001 OR
- 1001 OR (alias)
- 0010 ADD
- 0110 SUB (A-B)
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0111 SRA (arithmetic, sign bit replicated)
- 1000 EQ: result = 1 if A==B, else 0
- 1100 SLT: signed compare, result = 1 if A<B, else 0
- Any other code: result = 0. It is not an error.

State machine: IDLE, SHIFT, DONE.
- IDLE: `in_ready` = 1. On `in_valid`:
  - Non-shift op: compute and register the result, go to DONE.
  - Shift with amount 0: register A, go to DONE.
  - Shift with amount n > 0: load the working register with A and the counter with n, go to SHIFT.
- SHIFT: each cycle, shift the working register by 1 in the selected direction and decrement the counter. When the counter reaches 1, that shift is the final one and the state goes to DONE. `in_ready` = 0.
- DONE: `out_valid` = 1. `ALUResult` and `Zero` are stable until the handshake completes.
  - On `out_ready`, the unit may accept a new op in the same cycle: `in_ready` = `out_ready` in DONE.
  - If no new op arrives, go to IDLE.
- `Zero` is derived from the registered result; it is never computed combinationally from the inputs.
- Operands and `Operation` are captured at acceptance. Later changes on the inputs have no effect.

## Timing
- Reset (asynchronous): state = IDLE, `ALUResult` = 0, `Zero` = 1, `out_valid` = 0, internal counter = 0. `in_ready` = 1 after reset deasserts.
- Latency from acceptance at cycle T to `out_valid`:
  - Non-shift op, or shift by 0: T+1.
  - Shift by n: T+1+n, so the worst case is T+`DATA_W`.
- Throughput:
  - One non-shift op per cycle while `out_ready` is held high (back-to-back through DONE).
  - Shifts block input for n cycles.
- Output handshake: `out_valid` never drops without `out_ready` or `flush`. Data does not change while `out_valid`=1 and `out_ready`=0.
- Flush:
  - `flush` has priority over everything else. Next state = IDLE, `out_valid` = 0.
  - The operation presented that cycle is not accepted: `in_ready` = 0 while `flush`=1.
  - `ALUResult` keeps its last value.
- `reset` asserted mid-shift abandons the shift immediately. No partial result becomes visible.

## Test plan
- ADD 0x7FFFFFFF + 1, and SUB 0 - 1 -> ALUResult 0x80000000 and 0xFFFFFFFF respectively, both with `out_valid` at T+1 and `Zero` = 0. SUB 5-5 -> 0, `Zero` = 1.
- SRA A=0x80000000 by 31 -> `in_ready` low for 31 cycles, result 0xFFFFFFFF at T+32. SRL of the same -> 0x00000001. SLL by 0 -> A at T+1.
- SLT A=0xFFFFFFFF (-1), B=1 -> 1. EQ 0x1234 vs 0x1234 -> 1. Undefined code 1111 -> 0, `Zero` = 1.
- Backpressure: hold `out_ready`=0 for 5 cycles while changing the inputs -> `ALUResult`/`Zero` stable and `in_ready`=0. Then raise `out_ready` together with `in_valid` ADD -> new result the following cycle, with no bubble.
- `flush` during SHIFT (cycle 3 of 10) and during DONE -> `out_valid`=0 next cycle, IDLE, and the next op completes normally.
- `reset` pulse mid-shift -> all outputs at reset values immediately. After release, an XOR 0xF0F0 ^ 0xFF00 -> 0x0FF0.
